// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port between ALU and load.
// One-entry holding slot per requester, round-robin on contention.
module regs_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_rw,
  input  logic [DW-1:0]     a_din,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [AW-1:0]     m_rw,
  input  logic [DW-1:0]     m_din,
  output logic              we,
  output logic [AW-1:0]     rw,
  output logic [DW-1:0]     din,
  output logic [2**AW-1:0]  pending,
  output logic [CW-1:0]     wr_count
);

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_M = 1'b1
  } ptr_e;

  ptr_e          ptr_q, ptr_d;
  logic          hold_a_v_q, hold_a_v_d;
  logic [AW-1:0] hold_a_rw_q, hold_a_rw_d;
  logic [DW-1:0] hold_a_din_q, hold_a_din_d;
  logic          hold_m_v_q, hold_m_v_d;
  logic [AW-1:0] hold_m_rw_q, hold_m_rw_d;
  logic [DW-1:0] hold_m_din_q, hold_m_din_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic          grant_a, grant_m;
  logic          acc_a, acc_m;

  assign grant_a = hold_a_v_q &&
                   (!hold_m_v_q || ptr_q == PTR_A);
  assign grant_m = hold_m_v_q &&
                   (!hold_a_v_q || ptr_q == PTR_M);

  assign a_ready = !hold_a_v_q || grant_a;
  assign m_ready = !hold_m_v_q || grant_m;

  // Writes to $0 are acknowledged but never held.
  assign acc_a = a_valid && a_ready && (a_rw != '0);
  assign acc_m = m_valid && m_ready && (m_rw != '0);

  assign wr_count = wr_count_q;

  always_comb begin
    we  = 1'b0;
    rw  = '0;
    din = '0;
    unique case (1'b1)
      grant_a: begin
        we  = 1'b1;
        rw  = hold_a_rw_q;
        din = hold_a_din_q;
      end
      grant_m: begin
        we  = 1'b1;
        rw  = hold_m_rw_q;
        din = hold_m_din_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending = '0;
    if (hold_a_v_q) pending[hold_a_rw_q] = 1'b1;
    if (hold_m_v_q) pending[hold_m_rw_q] = 1'b1;
    pending[0] = 1'b0;
  end

  always_comb begin
    hold_a_v_d   = hold_a_v_q;
    hold_a_rw_d  = hold_a_rw_q;
    hold_a_din_d = hold_a_din_q;
    hold_m_v_d   = hold_m_v_q;
    hold_m_rw_d  = hold_m_rw_q;
    hold_m_din_d = hold_m_din_q;
    ptr_d        = ptr_q;
    wr_count_d   = wr_count_q;
    if (grant_a) hold_a_v_d = 1'b0;
    if (grant_m) hold_m_v_d = 1'b0;
    if (acc_a) begin
      hold_a_v_d   = 1'b1;
      hold_a_rw_d  = a_rw;
      hold_a_din_d = a_din;
    end
    if (acc_m) begin
      hold_m_v_d   = 1'b1;
      hold_m_rw_d  = m_rw;
      hold_m_din_d = m_din;
    end
    if (hold_a_v_q && hold_m_v_q)
      ptr_d = (ptr_q == PTR_A) ? PTR_M : PTR_A;
    if (we) wr_count_d = wr_count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= PTR_A;
      hold_a_v_q   <= 1'b0;
      hold_a_rw_q  <= '0;
      hold_a_din_q <= '0;
      hold_m_v_q   <= 1'b0;
      hold_m_rw_q  <= '0;
      hold_m_din_q <= '0;
      wr_count_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      hold_a_v_q   <= hold_a_v_d;
      hold_a_rw_q  <= hold_a_rw_d;
      hold_a_din_q <= hold_a_din_d;
      hold_m_v_q   <= hold_m_v_d;
      hold_m_rw_q  <= hold_m_rw_d;
      hold_m_din_q <= hold_m_din_d;
      wr_count_q   <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: expected writes queued at stimulus,
// popped by a monitor whenever the write port fires.
module tb_regs_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [AW-1:0]     a_rw = '0;
  logic [DW-1:0]     a_din = '0;
  logic              m_valid = 1'b0;
  logic              m_ready;
  logic [AW-1:0]     m_rw = '0;
  logic [DW-1:0]     m_din = '0;
  logic              we;
  logic [AW-1:0]     rw;
  logic [DW-1:0]     din;
  logic [2**AW-1:0]  pending;
  logic [CW-1:0]     wr_count;

  regs_wb_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_rw(a_rw), .a_din(a_din),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_rw(m_rw), .m_din(m_din),
    .we(we), .rw(rw), .din(din),
    .pending(pending), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rw;
    logic [DW-1:0] din;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, rw, din}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rw", 64'(rw), 64'(e.rw));
        chk("wr_din", 64'(din), 64'(e.din));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  wr_t sa[3];
  wr_t sm[3];

  initial begin
    int ia, im, cyc, first, last;
    logic fa, fm;

    #3;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_rw", 64'(rw), 64'd0);
    chk("rst_din", 64'(din), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_m_ready", 64'(m_ready), 64'd1);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_we", 64'(we), 64'd0);
    chk("idle_pending", 64'(pending), 64'd0);
    chk("idle_wr_count", 64'(wr_count), 64'd0);

    // single ALU write
    a_valid = 1'b1; a_rw = 5'd16; a_din = 32'd15;
    exp_q.push_back('{5'd16, 32'd15});
    tick();
    a_valid = 1'b0;
    chk("single_we", 64'(we), 64'd1);
    chk("single_pend16", 64'(pending[16]), 64'd1);
    tick();
    chk("single_pend_clr", 64'(pending), 64'd0);
    chk("single_count", 64'(wr_count), 64'd1);

    // simultaneous accept, pointer at a
    a_valid = 1'b1; a_rw = 5'd17; a_din = 32'd25;
    m_valid = 1'b1; m_rw = 5'd18; m_din = 32'd666;
    exp_q.push_back('{5'd17, 32'd25});
    exp_q.push_back('{5'd18, 32'd666});
    tick();
    a_valid = 1'b0; m_valid = 1'b0;
    chk("cont_rw_a", 64'(rw), 64'd17);
    chk("cont_m_ready", 64'(m_ready), 64'd0);
    chk("cont_pend18_c1", 64'(pending[18]), 64'd1);
    tick();
    chk("cont_rw_m", 64'(rw), 64'd18);
    chk("cont_pend18_c2", 64'(pending[18]), 64'd1);
    tick();
    chk("cont_pend_clr", 64'(pending), 64'd0);
    chk("cont_count", 64'(wr_count), 64'd3);

    // streaming; pointer now favours m
    sa[0] = '{5'd1, 32'd100}; sa[1] = '{5'd2, 32'd101};
    sa[2] = '{5'd3, 32'd102};
    sm[0] = '{5'd11, 32'd200}; sm[1] = '{5'd12, 32'd201};
    sm[2] = '{5'd13, 32'd202};
    exp_q.push_back(sm[0]); exp_q.push_back(sa[0]);
    exp_q.push_back(sm[1]); exp_q.push_back(sa[1]);
    exp_q.push_back(sm[2]); exp_q.push_back(sa[2]);
    ia = 0; im = 0; first = -1; last = -1;
    a_valid = 1'b1; a_rw = sa[0].rw; a_din = sa[0].din;
    m_valid = 1'b1; m_rw = sm[0].rw; m_din = sm[0].din;
    for (cyc = 0; cyc < 20; cyc++) begin
      fa = a_valid && a_ready;
      fm = m_valid && m_ready;
      tick();
      if (fa) ia++;
      if (fm) im++;
      a_valid = (ia < 3);
      m_valid = (im < 3);
      if (ia < 3) begin a_rw = sa[ia].rw; a_din = sa[ia].din; end
      if (im < 3) begin m_rw = sm[im].rw; m_din = sm[im].din; end
      if (we) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    a_valid = 1'b0; m_valid = 1'b0;
    chk("stream_span", 64'(last - first + 1), 64'd6);
    chk("stream_count", 64'(wr_count), 64'd9);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // write to $0 is swallowed
    m_valid = 1'b1; m_rw = 5'd0; m_din = 32'hDEAD;
    chk("r0_m_ready", 64'(m_ready), 64'd1);
    tick();
    m_valid = 1'b0;
    chk("r0_we", 64'(we), 64'd0);
    chk("r0_pending", 64'(pending), 64'd0);
    tick();
    chk("r0_count", 64'(wr_count), 64'd9);

    // reset with both slots full
    a_valid = 1'b1; a_rw = 5'd5; a_din = 32'h55;
    m_valid = 1'b1; m_rw = 5'd9; m_din = 32'h99;
    @(posedge clk);
    #2;
    a_valid = 1'b0; m_valid = 1'b0;
    chk("full_pending", 64'(pending), 64'h220);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pending", 64'(pending), 64'd0);
    chk("rst_mid_we", 64'(we), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rst_mid_count", 64'(wr_count), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
